// File: rtl/opcode_issue.sv
// Opcode-issue controller: buffers fetched opcode bytes and hands one to the microcode
// sequencer per micro-program boundary, with kill flushing and boundary-aligned mode switches.
module opcode_issue #(
    parameter int DEPTH         = 4,
    parameter int FLUSH_CYCLES  = 2,
    parameter bit JS_MODE_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_opcode,
    output logic        fetch_ready,
    input  logic        mode_req_valid,
    input  logic        mode_req_js,
    output logic        mode_busy,
    input  logic        mc__more_2a,
    input  logic        be_stall,
    input  logic        kill_4a,
    output logic [7:0]  opcode,
    output logic        js_mode,
    output logic        mc__stall,
    output logic [15:0] issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [FW-1:0]   r_flushCnt;
    logic            r_modePending;
    logic            r_modeReq;
    logic            r_jsMode;
    logic [15:0]     r_issued;

    logic w_boundary;
    logic w_empty;
    logic w_full;
    logic w_isRun;
    logic w_isFlush;
    logic w_stall;
    logic w_ready;
    logic w_push;
    logic w_consume;
    logic w_modeApply;

    assign w_boundary  = !mc__more_2a;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_isRun     = (r_state == ST_RUN);
    assign w_isFlush   = (r_state == ST_FLUSH);
    // A pending mode switch holds the boundary so the next opcode decodes under the new mode.
    assign w_stall     = be_stall | w_isFlush | (w_boundary & w_empty) | (w_boundary & r_modePending);
    assign w_ready     = !w_full & w_isRun & !kill_4a;
    assign w_push      = fetch_valid & w_ready;
    assign w_consume   = w_boundary & !w_stall & !kill_4a & w_isRun;
    assign w_modeApply = r_modePending & w_boundary & w_isRun & !kill_4a & !be_stall;

    assign fetch_ready  = w_ready;
    assign mc__stall    = w_stall;
    assign mode_busy    = r_modePending;
    assign js_mode      = r_jsMode;
    assign issued_count = r_issued;
    assign opcode       = w_empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= fetch_opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_flushCnt    <= '0;
            r_modePending <= 1'b0;
            r_modeReq     <= 1'b0;
            r_jsMode      <= JS_MODE_RESET;
            r_issued      <= 16'h0000;
        end else begin
            if (kill_4a) begin
                r_state    <= ST_FLUSH;
                r_flushCnt <= FW'(FLUSH_CYCLES);
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_push) begin
                            r_wptr <= r_wptr + 1'b1;
                        end
                        if (w_consume) begin
                            r_rptr <= r_rptr + 1'b1;
                        end
                        if (w_push && !w_consume) begin
                            r_count <= r_count + 1'b1;
                        end else if (!w_push && w_consume) begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_flushCnt <= FW'(1)) begin
                            r_state <= ST_RUN;
                        end
                        if (r_flushCnt != '0) begin
                            r_flushCnt <= r_flushCnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                    end
                endcase
            end

            if (w_consume) begin
                r_issued <= r_issued + 16'd1;
            end

            // A request arriving on the apply cycle stays pending for the following boundary.
            if (w_modeApply) begin
                r_jsMode      <= r_modeReq;
                r_modePending <= 1'b0;
            end
            if (mode_req_valid) begin
                r_modeReq     <= mode_req_js;
                r_modePending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opcode_issue.sv
// Self-checking bench for opcode_issue: scoreboard of pushed opcodes, checked as the
// sequencer consumes them, plus scenario tasks for fill, kill, mode switch, stall and wrap.
module tb_opcode_issue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [7:0]  fetch_opcode;
    logic        fetch_ready;
    logic        mode_req_valid;
    logic        mode_req_js;
    logic        mode_busy;
    logic        mc__more_2a;
    logic        be_stall;
    logic        kill_4a;
    logic [7:0]  opcode;
    logic        js_mode;
    logic        mc__stall;
    logic [15:0] issued_count;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  expQ[$];
    int          expIssued = 0;

    opcode_issue #(
        .DEPTH(DEPTH),
        .FLUSH_CYCLES(2),
        .JS_MODE_RESET(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_valid(fetch_valid),
        .fetch_opcode(fetch_opcode),
        .fetch_ready(fetch_ready),
        .mode_req_valid(mode_req_valid),
        .mode_req_js(mode_req_js),
        .mode_busy(mode_busy),
        .mc__more_2a(mc__more_2a),
        .be_stall(be_stall),
        .kill_4a(kill_4a),
        .opcode(opcode),
        .js_mode(js_mode),
        .mc__stall(mc__stall),
        .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_valid = 1'b0; fetch_opcode = 8'h00; mode_req_valid = 1'b0;
        mode_req_js = 1'b0; mc__more_2a = 1'b0; be_stall = 1'b0; kill_4a = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall: got %b want 1", mc__stall); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", fetch_ready); end
        checks++; if (mode_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", mode_busy); end
        checks++; if (js_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_js: got %b want 0", js_mode); end
        checks++; if (issued_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_count: got %h want 0000", issued_count); end
        checks++; if (opcode !== 8'h00) begin errors++; $display("[TB] FAIL reset_opcode: got %h want 00", opcode); end
        tick();
    endtask

    task automatic test_basic();
        fetch_valid = 1'b1; fetch_opcode = 8'h12;
        @(negedge clk);
        checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_stall0: got %b want 1", mc__stall); end
        checks++; if (opcode !== 8'h00) begin errors++; $display("[TB] FAIL basic_op0: got %h want 00", opcode); end
        expQ.push_back(8'h12);
        tick();
        fetch_opcode = 8'h34;
        @(negedge clk);
        checks++; if (mc__stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_stall1: got %b want 0", mc__stall); end
        checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL basic_op1: got %h want %h", opcode, expQ[0]); end
        void'(expQ.pop_front()); expIssued++;
        expQ.push_back(8'h34);
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL basic_op2: got %h want %h", opcode, expQ[0]); end
        void'(expQ.pop_front()); expIssued++;
        tick();
        @(negedge clk);
        checks++; if (issued_count !== 16'(expIssued)) begin errors++; $display("[TB] FAIL basic_count: got %0d want %0d", issued_count, expIssued); end
        checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_stall_empty: got %b want 1", mc__stall); end
        checks++; if (opcode !== 8'h00) begin errors++; $display("[TB] FAIL basic_op_empty: got %h want 00", opcode); end
        tick();
    endtask

    task automatic test_fill();
        logic expReady;
        mc__more_2a = 1'b1; fetch_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            fetch_opcode = 8'hA0 + 8'(i);
            expReady = (expQ.size() < DEPTH);
            @(negedge clk);
            checks++; if (fetch_ready !== expReady) begin errors++; $display("[TB] FAIL fill_ready%0d: got %b want %b", i, fetch_ready, expReady); end
            if (expReady) expQ.push_back(fetch_opcode);
            tick();
        end
        fetch_valid = 1'b0; mc__more_2a = 1'b0;
        @(negedge clk);
        checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL fill_pop: got %h want %h", opcode, expQ[0]); end
        void'(expQ.pop_front()); expIssued++;
        tick();
        mc__more_2a = 1'b1;
        @(negedge clk);
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready_after: got %b want 1", fetch_ready); end
        checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL fill_head: got %h want %h", opcode, expQ[0]); end
        tick();
    endtask

    task automatic test_kill();
        fetch_valid = 1'b1; fetch_opcode = 8'hEE; kill_4a = 1'b1; mc__more_2a = 1'b0;
        @(negedge clk);
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL kill_ready: got %b want 0", fetch_ready); end
        tick();
        expQ.delete();
        kill_4a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_stall%0d: got %b want 1", i, mc__stall); end
            checks++; if (fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready%0d: got %b want 0", i, fetch_ready); end
            checks++; if (opcode !== 8'h00) begin errors++; $display("[TB] FAIL flush_op%0d: got %h want 00", i, opcode); end
            tick();
        end
        fetch_valid = 1'b0;
        @(negedge clk);
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_run_ready: got %b want 1", fetch_ready); end
        checks++; if (issued_count !== 16'(expIssued)) begin errors++; $display("[TB] FAIL kill_count: got %0d want %0d", issued_count, expIssued); end
        tick();
    endtask

    task automatic test_mode();
        mc__more_2a = 1'b1; mode_req_valid = 1'b1; mode_req_js = 1'b1;
        fetch_valid = 1'b1; fetch_opcode = 8'h5A;
        @(negedge clk);
        checks++; if (js_mode !== 1'b0) begin errors++; $display("[TB] FAIL mode_js0: got %b want 0", js_mode); end
        expQ.push_back(8'h5A);
        tick();
        mode_req_valid = 1'b0; fetch_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (js_mode !== 1'b0) begin errors++; $display("[TB] FAIL mode_hold_js%0d: got %b want 0", i, js_mode); end
            checks++; if (mode_busy !== 1'b1) begin errors++; $display("[TB] FAIL mode_busy%0d: got %b want 1", i, mode_busy); end
            tick();
        end
        mc__more_2a = 1'b0;
        @(negedge clk);
        checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL mode_apply_stall: got %b want 1", mc__stall); end
        checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL mode_apply_op: got %h want %h", opcode, expQ[0]); end
        tick();
        @(negedge clk);
        checks++; if (js_mode !== 1'b1) begin errors++; $display("[TB] FAIL mode_js1: got %b want 1", js_mode); end
        checks++; if (mode_busy !== 1'b0) begin errors++; $display("[TB] FAIL mode_busy_clear: got %b want 0", mode_busy); end
        checks++; if (mc__stall !== 1'b0) begin errors++; $display("[TB] FAIL mode_pop_stall: got %b want 0", mc__stall); end
        checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL mode_pop_op: got %h want %h", opcode, expQ[0]); end
        void'(expQ.pop_front()); expIssued++;
        tick();
        @(negedge clk);
        checks++; if (issued_count !== 16'(expIssued)) begin errors++; $display("[TB] FAIL mode_count: got %0d want %0d", issued_count, expIssued); end
        tick();
    endtask

    task automatic test_reset_mid();
        mc__more_2a = 1'b1; fetch_valid = 1'b1; fetch_opcode = 8'h99;
        mode_req_valid = 1'b1; mode_req_js = 1'b0;
        tick();
        fetch_valid = 1'b0; mode_req_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; mc__more_2a = 1'b0;
        expQ.delete(); expIssued = 0;
        @(negedge clk);
        checks++; if (opcode !== 8'h00) begin errors++; $display("[TB] FAIL rmid_op: got %h want 00", opcode); end
        checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL rmid_stall: got %b want 1", mc__stall); end
        checks++; if (mode_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b want 0", mode_busy); end
        checks++; if (js_mode !== 1'b0) begin errors++; $display("[TB] FAIL rmid_js: got %b want 0", js_mode); end
        checks++; if (issued_count !== 16'(expIssued)) begin errors++; $display("[TB] FAIL rmid_count: got %0d want %0d", issued_count, expIssued); end
        tick();
    endtask

    task automatic test_be_stall();
        mc__more_2a = 1'b1; fetch_valid = 1'b1; fetch_opcode = 8'h77;
        expQ.push_back(8'h77);
        tick();
        fetch_valid = 1'b0; mc__more_2a = 1'b0; be_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (mc__stall !== 1'b1) begin errors++; $display("[TB] FAIL bes_stall%0d: got %b want 1", i, mc__stall); end
            checks++; if (opcode !== expQ[0]) begin errors++; $display("[TB] FAIL bes_op%0d: got %h want %h", i, opcode, expQ[0]); end
            tick();
        end
        be_stall = 1'b0;
        @(negedge clk);
        checks++; if (mc__stall !== 1'b0) begin errors++; $display("[TB] FAIL bes_release: got %b want 0", mc__stall); end
        checks++; if (issued_count !== 16'(expIssued)) begin errors++; $display("[TB] FAIL bes_count: got %0d want %0d", issued_count, expIssued); end
        void'(expQ.pop_front()); expIssued++;
        tick();
        @(negedge clk);
        checks++; if (opcode !== 8'h00) begin errors++; $display("[TB] FAIL bes_empty: got %h want 00", opcode); end
        tick();
    endtask

    task automatic test_wrap();
        int bad;
        int k;
        bad = 0;
        k = 65535 - expIssued;
        mc__more_2a = 1'b0; fetch_valid = 1'b1;
        for (int i = 0; i < k; i++) begin
            fetch_opcode = 8'(i);
            @(negedge clk);
            if (expQ.size() > 0) begin
                if (opcode !== expQ[0]) bad++;
                void'(expQ.pop_front()); expIssued++;
            end
            expQ.push_back(8'(i));
            tick();
        end
        fetch_valid = 1'b0;
        @(negedge clk);
        if (opcode !== expQ[0]) bad++;
        void'(expQ.pop_front()); expIssued++;
        tick();
        @(negedge clk);
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL wrap_stream: %0d opcodes differed, want 0", bad); end
        checks++; if (issued_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_ffff: got %h want ffff", issued_count); end
        fetch_valid = 1'b1; fetch_opcode = 8'hC3;
        tick();
        fetch_valid = 1'b0;
        @(negedge clk);
        checks++; if (opcode !== 8'hC3) begin errors++; $display("[TB] FAIL wrap_op: got %h want c3", opcode); end
        tick();
        @(negedge clk);
        checks++; if (issued_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h want 0000", issued_count); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_kill();
        test_mode();
        test_reset_mid();
        test_be_stall();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
